// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver with sync-marker word alignment and a valid/ready output.
// Optional even-parity bit after each word when DESER_PARITY_EN is defined.
module deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_i,
    input  logic             bit_vld,
    input  logic             sync,
    input  logic             data_rdy,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] par_data,
    output logic             data_vld,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy,
    output logic             parity_err
);
    localparam int CW = $clog2(WIDTH) + 1;

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_par_data;
    logic             r_data_vld;
    logic             r_overrun;
    logic             r_frame_err;
`ifdef DESER_PARITY_EN
    logic             r_parity_err;
`endif

    // A same-cycle accept frees the output slot for a newly completed word.
    logic             w_free;
    logic [WIDTH-1:0] w_word;

    assign w_free = !r_data_vld || data_rdy;
    assign w_word = {r_shreg[WIDTH-2:0], ser_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_par_data   <= '0;
            r_data_vld   <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef DESER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            if (r_data_vld && data_rdy) r_data_vld <= 1'b0;
            if (clr_ovr) r_overrun <= 1'b0;

            if (bit_vld) begin
                if (sync) begin
                    if (r_state != IDLE) r_frame_err <= 1'b1;
                    r_shreg <= {{(WIDTH-1){1'b0}}, ser_i};
                    r_cnt   <= CW'(1);
                    r_state <= SHIFT;
                end else begin
                    case (r_state)
                        IDLE: ;
                        SHIFT: begin
                            r_shreg <= w_word;
                            r_cnt   <= r_cnt + CW'(1);
                            if (r_cnt == CW'(WIDTH-1)) begin
`ifdef DESER_PARITY_EN
                                r_state <= PAR;
`else
                                r_state <= IDLE;
                                if (w_free) begin
                                    r_par_data <= w_word;
                                    r_data_vld <= 1'b1;
                                end else begin
                                    r_overrun  <= 1'b1;
                                end
`endif
                            end
                        end
`ifdef DESER_PARITY_EN
                        PAR: begin
                            r_state <= IDLE;
                            if (w_free) begin
                                r_par_data   <= r_shreg;
                                r_parity_err <= (^r_shreg) ^ ser_i;
                                r_data_vld   <= 1'b1;
                            end else begin
                                r_overrun    <= 1'b1;
                            end
                        end
`endif
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign par_data  = r_par_data;
    assign data_vld  = r_data_vld;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);
`ifdef DESER_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: a word-level reference model checked every cycle, plus literal checks.
module tb_deserializer;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ser_i, bit_vld, sync, data_rdy, clr_ovr;
    logic [WIDTH-1:0] par_data;
    logic             data_vld, overrun, frame_err, busy, parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_ferr   = 0;
    bit rdy      = 1'b0;

    deserializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .ser_i(ser_i), .bit_vld(bit_vld), .sync(sync),
        .data_rdy(data_rdy), .clr_ovr(clr_ovr), .par_data(par_data),
        .data_vld(data_vld), .overrun(overrun), .frame_err(frame_err),
        .busy(busy), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Reference model: a word in progress is a count of bits collected so far.
    bit               m_active;
    int               m_nbits;
    logic [WIDTH-1:0] m_word;
    logic [WIDTH-1:0] m_data;
    bit               m_vld, m_ovr, m_ferr, m_perr, m_free;

    task automatic m_deliver(input logic [WIDTH-1:0] w, input bit p);
        if (m_free) begin
            m_vld  = 1'b1;
            m_data = w;
            m_perr = p;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_nbits = 0; m_word = '0; m_data = '0;
            m_vld = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
        end else begin
            m_free = !m_vld || data_rdy;
            m_ferr = 1'b0;
            if (m_vld && data_rdy) m_vld = 1'b0;
            if (clr_ovr) m_ovr = 1'b0;
            if (bit_vld) begin
                if (sync) begin
                    m_ferr   = m_active;
                    m_active = 1;
                    m_nbits  = 1;
                    m_word   = WIDTH'(ser_i);
                end else if (m_active) begin
                    if (m_nbits < WIDTH) begin
                        m_word  = {m_word[WIDTH-2:0], ser_i};
                        m_nbits = m_nbits + 1;
`ifndef DESER_PARITY_EN
                        if (m_nbits == WIDTH) begin
                            m_deliver(m_word, 1'b0);
                            m_active = 0;
                        end
`endif
                    end else begin
                        m_deliver(m_word, ($countones(m_word) % 2 == 1) ^ ser_i);
                        m_active = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr++;
        chk("data_vld", int'(data_vld), int'(m_vld));
        if (m_vld) chk("par_data", int'(par_data), int'(m_data));
        if (m_vld) chk("parity_err", int'(parity_err), int'(m_perr));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("frame_err", int'(frame_err), int'(m_ferr));
        chk("busy", int'(busy), int'(m_active));
    end

    task automatic tick(input bit bv, input bit sy, input bit b, input bit cl, input bit rx);
        @(negedge clk);
        #1;
        bit_vld  = bv;
        sync     = sy;
        ser_i    = b;
        clr_ovr  = cl;
        data_rdy = rdy | rx;
        @(posedge clk);
        #1;
        bit_vld  = 1'b0;
        sync     = 1'b0;
        clr_ovr  = 1'b0;
        data_rdy = rdy;
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] w, input int n, input int gap,
                             input bit clr_last, input bit rdy_last);
        for (int i = 0; i < n; i++) begin
            if (i > 0)
                for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            tick(1'b1, i == 0, w[WIDTH-1-i], (i == n-1) && clr_last, (i == n-1) && rdy_last);
        end
    endtask

    // Sends a full word; with parity enabled a correct even-parity bit follows.
    task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input bit clr_last, input bit rdy_last);
`ifdef DESER_PARITY_EN
        send_bits(w, WIDTH, gap, 1'b0, 1'b0);
        tick(1'b1, 1'b0, ^w, clr_last, rdy_last);
`else
        send_bits(w, WIDTH, gap, clr_last, rdy_last);
`endif
    endtask

    initial begin
        int f0;
        rst = 1'b1; ser_i = 0; bit_vld = 0; sync = 0; data_rdy = 0; clr_ovr = 0;
        repeat (3) @(negedge clk);
        chk("reset par_data", int'(par_data), 0);
        chk("reset data_vld", int'(data_vld), 0);
        chk("reset busy", int'(busy), 0);
        #1 rst = 1'b0;

        // Basic receive
        rdy = 1'b1;
        send_word(8'hA5, 0, 0, 0);
        chk("basic par_data", int'(par_data), 'hA5);
        chk("basic data_vld", int'(data_vld), 1);
        chk("basic busy", int'(busy), 0);
        tick(0, 0, 0, 0, 0);

        // Gapped strobes with a pre-sync bit in IDLE
        tick(1, 0, 1, 0, 0);
        send_word(8'h3C, 2, 0, 0);
        chk("gapped par_data", int'(par_data), 'h3C);
        chk("gapped data_vld", int'(data_vld), 1);
        tick(0, 0, 0, 0, 0);

        // Backpressure and overrun
        rdy = 1'b0;
        send_word(8'h11, 0, 0, 0);
        send_word(8'h22, 0, 0, 0);
        chk("bp par_data", int'(par_data), 'h11);
        chk("bp overrun", int'(overrun), 1);
        rdy = 1'b1;
        tick(0, 0, 0, 1, 0);
        chk("bp drained", int'(data_vld), 0);
        chk("bp clr_ovr", int'(overrun), 0);
        rdy = 1'b0;
        send_word(8'h33, 0, 0, 0);
        send_word(8'h34, 0, 1, 0);
        chk("clr vs drop overrun", int'(overrun), 1);
        chk("clr vs drop par_data", int'(par_data), 'h33);
        rdy = 1'b1;
        tick(0, 0, 0, 1, 0);

        // Simultaneous accept frees the slot
        rdy = 1'b0;
        send_word(8'h44, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        send_word(8'h55, 0, 0, 1);
        chk("simul par_data", int'(par_data), 'h55);
        chk("simul data_vld", int'(data_vld), 1);
        chk("simul overrun", int'(overrun), 0);
        rdy = 1'b1;
        tick(0, 0, 0, 0, 0);

        // Resync mid-word
        f0 = n_ferr;
        send_bits(8'hC3, 4, 0, 0, 0);
        send_word(8'hF0, 0, 0, 0);
        chk("resync par_data", int'(par_data), 'hF0);
        tick(0, 0, 0, 0, 0);
        chk("resync frame_err pulses", n_ferr - f0, 1);

        // Reset mid-word, with a pending word
        rdy = 1'b0;
        send_word(8'h5A, 0, 0, 0);
        send_bits(8'h81, 3, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst data_vld", int'(data_vld), 0);
        chk("midrst par_data", int'(par_data), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst frame_err", int'(frame_err), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        rdy = 1'b1;
        send_word(8'h81, 1, 0, 0);
        chk("post-rst par_data", int'(par_data), 'h81);

        // Sustained back-to-back stream
        for (int k = 0; k < 6; k++) send_word(WIDTH'(8'h17 * (k + 1)), 0, 0, 0);
        chk("stream last", int'(par_data), 'h17 * 6);

`ifdef DESER_PARITY_EN
        send_bits(8'h03, WIDTH, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("parity ok", int'(parity_err), 0);
        chk("parity ok data", int'(par_data), 'h03);
        send_bits(8'h07, WIDTH, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("parity bad", int'(parity_err), 1);
        chk("parity bad data", int'(par_data), 'h07);
`endif
        repeat (3) tick(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
Serial-to-parallel receiver. It is the companion of the team's MSB-first parallel-to-serial serializer.
- Samples ser_i on each bit_vld strobe.
- Aligns word boundaries using a sync marker on the first bit.
- Assembles WIDTH bits, MSB first, and presents the word on a valid/ready output with overrun and framing error reporting.
- Sits at the receive end of the serial link, feeding downstream parallel logic.

Parameters:
WIDTH, 8, word width in bits (>=2); bit counter width is clog2(WIDTH)+1

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
ser_i  input  1  serial data bit, MSB of each word first
bit_vld  input  1  ser_i (and sync) sampled only on cycles where bit_vld=1
sync  input  1  qualified by bit_vld; marks the current bit as the first (MSB) bit of a word
data_rdy  input  1  downstream accepts par_data when data_vld&&data_rdy
clr_ovr  input  1  synchronous clear of the sticky overrun flag
par_data  output  WIDTH  assembled word, stable while data_vld=1
data_vld  output  1  par_data holds an unconsumed word
overrun  output  1  sticky: a completed word was dropped because the output was still occupied
frame_err  output  1  one-cycle pulse: sync arrived mid-word and the partial word was discarded
busy  output  1  1 while a word is being assembled (state != IDLE)
parity_err  output  1  parity result for the word on par_data (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, shift register=0, bit count=0.
  - par_data=0, data_vld=0, overrun=0, frame_err=0, busy=0, parity_err=0.
- Reset mid-word: the partial word is lost and any pending output word is lost. No error flag is raised.
- States: IDLE, SHIFT, PAR (PAR exists only with the macro).
- IDLE:
  - bit_vld&&!sync: bit ignored; stay IDLE.
  - bit_vld&&sync: shreg<=ser_i in the LSB; cnt<=1; go to SHIFT.
- SHIFT, on bit_vld&&!sync:
  - shreg<={shreg[WIDTH-2:0],ser_i}; cnt<=cnt+1.
  - When this bit is bit number WIDTH, the word is complete:
    - Without the macro: deliver the word and go to IDLE.
    - With the macro: go to PAR.
- SHIFT or PAR, on bit_vld&&sync: resync.
  - frame_err=1 for exactly one cycle.
  - Partial word discarded.
  - The current bit becomes bit 1 of the new word (cnt<=1, state SHIFT).
- No bit_vld in SHIFT or PAR: all state holds. There is no timeout.
- Deliver:
  - Output is free when data_vld=0, or when data_vld&&data_rdy in the same cycle (a simultaneous accept frees the slot).
  - If free: par_data<=word and data_vld=1 on the next cycle. Latency is 1 clk after the edge that samples the final bit.
  - If not free: the word is dropped, par_data and data_vld are unchanged, and overrun<=1.
- Output handshake:
  - data_vld&&data_rdy clears data_vld next cycle, unless a new word is delivered that same cycle, in which case data_vld stays 1 with the new data.
  - par_data never changes while data_vld=1 and data_rdy=0.
- Back-to-back words: a sync-qualified bit on the cycle right after the final bit is accepted. There are no dead cycles, and a sustained one-word-per-WIDTH-bits stream is supported.
- overrun:
  - Cleared only by clr_ovr or rst.
  - If clr_ovr coincides with a new drop, overrun stays 1 (set wins).
- busy = (state != IDLE).

Optional Feature:
DESER_PARITY_EN
- Defined:
  - After bit WIDTH, the FSM enters PAR.
  - The next bit_vld&&!sync samples the even-parity bit. An error is flagged when (^word)^ser_i = 1.
  - The word is then delivered as normal. parity_err is loaded alongside par_data and held with it.
  - sync in PAR resyncs exactly as in SHIFT; the word is discarded.
  - An overrun drop also discards the parity result.
- Not defined: PAR state is absent, words complete after WIDTH bits, and parity_err is tied to 0.

Test Plan:
- Basic receive: data_rdy=1; bits of 0xA5 MSB first with sync on the first bit and bit_vld every cycle -> data_vld pulses 1 clk after the 8th sample with par_data=0xA5; frame_err=0; busy=0 afterwards.
- Gapped strobes: bit_vld on every third cycle, word 0x3C, idle cycles carry junk ser_i; also a non-sync bit_vld in IDLE beforehand -> par_data=0x3C; the junk and the pre-sync bit are ignored.
- Backpressure and overrun: data_rdy=0; send 0x11 then 0x22 back-to-back -> par_data stays 0x11, overrun=1 after the 0x22 completes. Then raise data_rdy and pulse clr_ovr -> data_vld drops, overrun=0. Also drive clr_ovr in the same cycle as a drop -> overrun stays 1.
- Simultaneous accept: data_rdy=1 only on the cycle 0x55 completes while 0x44 is pending -> 0x44 consumed, par_data=0x55, data_vld stays 1, no overrun.
- Resync and reset: sync on the 5th bit of a word, followed by 0xF0 -> one-cycle frame_err, par_data=0xF0. Assert rst after bit 3 of 0x81 -> all outputs 0, IDLE; the next clean 0x81 is received correctly.
- With DESER_PARITY_EN: send 0x03 with parity bit 0 -> parity_err=0. Send 0x07 with parity bit 0 -> parity_err=1, par_data=0x07.
